// File: rtl/control_mc.sv
// control_mc: multi-cycle control FSM for the 16-bit processor.
// Sequences fetch/decode/execute/memory/writeback from the IR opcode, stalls
// on the memory ready handshake, traps on illegal opcodes or wait timeouts,
// and counts retired instructions.
module control_mc #(
    parameter int OPW           = 7,
    parameter int MEM_HANDSHAKE = 1,
    parameter int MEM_TIMEOUT   = 15,
    parameter int CNTW          = 16
) (
    input  logic            CLK,
    input  logic            Reset_n,
    input  logic [OPW-1:0]  input_control,
    input  logic            MemReady,
    output logic            output_control_Branch,
    output logic            output_control_IoD,
    output logic            output_control_IRWrite,
    output logic            output_control_Mem2Reg,
    output logic            output_control_MemR,
    output logic            output_control_MemW,
    output logic            output_control_PCSrc,
    output logic            output_control_PCWrite,
    output logic            output_control_RegWrite,
    output logic [1:0]      output_control_ALUSrcA,
    output logic [1:0]      output_control_ALUSrcB,
    output logic [1:0]      output_control_BranchType,
    output logic [3:0]      output_control_ALUOp,
    output logic [3:0]      output_control_current_state,
    output logic [3:0]      output_control_next_state,
    output logic            Trap,
    output logic [CNTW-1:0] InstrCount
);

    localparam int WW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [3:0] {
        S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_RTYPE = 4'd2,  S_RITYPE = 4'd3,
        S_RTEND = 4'd4,  S_LW1    = 4'd5,  S_LW2   = 4'd6,  S_SW     = 4'd7,
        S_JALR  = 4'd8,  S_BR     = 4'd9,  S_BR2   = 4'd10, S_JAL    = 4'd11,
        S_LW3   = 4'd12, S_TRAP   = 4'd13
    } state_t;

    typedef struct packed {
        logic       branch, iod, mem2reg, memr, memw, pcsrc, pcwrite, regwrite;
        logic [1:0] alusrca, alusrcb, brtype;
        logic [3:0] aluop;
        logic       trap;
    } ctl_t;

    state_t          state_q, state_d;
    ctl_t            ctl_q;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic [CNTW-1:0] icnt_q;
    logic            rdy, timeout, retire;
    logic [2:0]      cls;
    logic [3:0]      func;

    assign rdy  = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;
    assign cls  = input_control[OPW-1:OPW-3];
    assign func = input_control[3:0];

    // Moore control word for a state; IRWrite and Fetch's PCWrite are gated by ready outside.
    function automatic ctl_t moore(input state_t s, input logic [3:0] f);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH:  c.alusrcb = 2'b01;
            S_DECODE: c.alusrcb = 2'b11;
            S_RTYPE:  begin c.alusrca = 2'b01; c.aluop = f; end
            S_RITYPE: begin c.alusrca = 2'b01; c.alusrcb = 2'b10; c.aluop = f; end
            S_RTEND:  c.regwrite = 1'b1;
            S_LW1:    begin c.alusrca = 2'b01; c.alusrcb = 2'b10; end
            S_LW2:    begin c.iod = 1'b1; c.memr = 1'b1; end
            S_LW3:    begin c.regwrite = 1'b1; c.mem2reg = 1'b1; end
            S_SW:     begin c.iod = 1'b1; c.memw = 1'b1; end
            S_BR:     begin c.alusrca = 2'b01; c.aluop = 4'b0001; end
            S_BR2:    begin c.branch = 1'b1; c.pcsrc = 1'b1; c.brtype = f[1:0]; end
            S_JAL:    begin c.pcsrc = 1'b1; c.pcwrite = 1'b1; c.regwrite = 1'b1; end
            S_JALR:   begin
                c.pcsrc = 1'b1; c.pcwrite = 1'b1; c.regwrite = 1'b1;
                c.alusrca = 2'b01; c.alusrcb = 2'b10;
            end
            S_TRAP:   c.trap = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    // Next-state decode, wait counter update and retirement detection.
    always_comb begin
        state_d = state_q;
        timeout = (MEM_TIMEOUT != 0) && !rdy && (wcnt_q == WW'(MEM_TIMEOUT));
        case (state_q)
            S_FETCH:  state_d = rdy ? S_DECODE : (timeout ? S_TRAP : S_FETCH);
            S_DECODE: begin
                case (cls)
                    3'b001:         state_d = S_RTYPE;
                    3'b010:         state_d = S_RITYPE;
                    3'b011, 3'b100: state_d = S_LW1;
                    3'b101:         state_d = S_BR;
                    3'b110:         state_d = S_JAL;
                    3'b111:         state_d = S_JALR;
                    default:        state_d = S_TRAP;
                endcase
            end
            S_RTYPE, S_RITYPE: state_d = S_RTEND;
            S_RTEND:  state_d = S_FETCH;
            S_LW1:    state_d = (cls == 3'b011) ? S_LW2 : S_SW;
            S_LW2:    state_d = rdy ? S_LW3 : (timeout ? S_TRAP : S_LW2);
            S_LW3:    state_d = S_FETCH;
            S_SW:     state_d = rdy ? S_FETCH : (timeout ? S_TRAP : S_SW);
            S_BR:     state_d = S_BR2;
            S_BR2, S_JAL, S_JALR: state_d = S_FETCH;
            default:  state_d = S_TRAP;
        endcase
        // Count only while stalled in a wait state; entering or completing clears it.
        wcnt_d = ((state_q inside {S_FETCH, S_LW2, S_SW}) && !rdy && (state_d == state_q))
                 ? wcnt_q + 1'b1 : '0;
        retire = (state_d == S_FETCH) &&
                 (state_q inside {S_RTEND, S_LW3, S_SW, S_BR2, S_JAL, S_JALR});
    end

    // State, registered Moore controls, wait counter and retired-instruction count.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_FETCH;
            ctl_q   <= moore(S_FETCH, 4'd0);
            wcnt_q  <= '0;
            icnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= moore(state_d, func);
            wcnt_q  <= wcnt_d;
            if (retire) icnt_q <= icnt_q + 1'b1;
        end
    end

    assign output_control_Branch        = ctl_q.branch;
    assign output_control_IoD           = ctl_q.iod;
    assign output_control_IRWrite       = (state_q == S_FETCH) && rdy;
    assign output_control_Mem2Reg       = ctl_q.mem2reg;
    assign output_control_MemR          = ctl_q.memr;
    assign output_control_MemW          = ctl_q.memw;
    assign output_control_PCSrc         = ctl_q.pcsrc;
    assign output_control_PCWrite       = ctl_q.pcwrite | ((state_q == S_FETCH) && rdy);
    assign output_control_RegWrite      = ctl_q.regwrite;
    assign output_control_ALUSrcA       = ctl_q.alusrca;
    assign output_control_ALUSrcB       = ctl_q.alusrcb;
    assign output_control_BranchType    = ctl_q.brtype;
    assign output_control_ALUOp         = ctl_q.aluop;
    assign output_control_current_state = state_q;
    assign output_control_next_state    = state_d;
    assign Trap                         = ctl_q.trap;
    assign InstrCount                   = icnt_q;

endmodule
